// File: rtl/l2_port_scheduler_if.sv
// l2_port_scheduler_if
//  Bundles the icache, dcache and L2 sides of the shared L2 port.
//  slave  : view used by the scheduler (requests/L2 response in, L2 strobes/cache responses out)
//  master : view used by the surrounding caches/L2 model (the opposite directions)
//  Signals:
//    i_read/i_write/i_addr/i_wdata/i_mbe  icache request, held until i_resp
//    d_read/d_write/d_addr/d_wdata/d_mbe  dcache request, held until d_resp
//    l2_rdata/l2_resp                     L2 read line and completion pulse
//    i_rdata/i_resp, d_rdata/d_resp       per-cache response
//    l2_read/l2_write/l2_addr/l2_wdata/l2_mbe  latched request toward L2
//    busy                                 scheduler not idle
interface l2_port_scheduler_if #(
  parameter int LINE_W = 256
);
  localparam int MBE_W = LINE_W / 8;

  logic              i_read;
  logic              i_write;
  logic [31:0]       i_addr;
  logic [LINE_W-1:0] i_wdata;
  logic [MBE_W-1:0]  i_mbe;
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [MBE_W-1:0]  d_mbe;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [31:0]       l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [MBE_W-1:0]  l2_mbe;
  logic              busy;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata, i_mbe,
    input  d_read, d_write, d_addr, d_wdata, d_mbe,
    input  l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output l2_read, l2_write, l2_addr, l2_wdata, l2_mbe, busy
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata, i_mbe,
    output d_read, d_write, d_addr, d_wdata, d_mbe,
    output l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  l2_read, l2_write, l2_addr, l2_wdata, l2_mbe, busy
  );
endinterface

// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler
//  Shares the single L2 port between the icache and dcache miss paths. The winning
//  request is latched at grant and presented to L2 unchanged until l2_resp; the
//  response is routed only to the granted cache. Dcache wins ties, but after
//  STARVE_LIMIT dcache grants taken while the icache waited, the icache is forced in.
//  Ports:
//    clk  rising-edge clock
//    rst  synchronous active-high reset
//    bus  l2_port_scheduler_if.slave (cache requests, L2 side, responses, busy)
module l2_port_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_W       = 256
) (
  input logic                 clk,
  input logic                 rst,
  l2_port_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int MBE_W = LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              op_write_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [MBE_W-1:0]  mbe_q;

  logic i_pend;
  logic d_pend;
  logic force_i;
  logic grant_i;
  logic grant_d;
  logic serving;
  logic i_resp;
  logic d_resp;

  assign i_pend  = bus.i_read | bus.i_write;
  assign d_pend  = bus.d_read | bus.d_write;
  assign force_i = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    serving = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pend && (!d_pend || force_i)) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end else if (d_pend) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        serving = 1'b1;
        if (bus.l2_resp) begin
          i_resp  = 1'b1;
          state_d = RELEASE;
        end
      end
      SERVE_D: begin
        serving = 1'b1;
        if (bus.l2_resp) begin
          d_resp  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A dcache grant with force_i set implies the icache is idle, so the
  // increment below only needs to stop at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_pend && !force_i) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Request latch: captured only on the grant cycle, so requester-side changes
  // during the transaction never reach L2. Write wins when both ops are raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mbe_q      <= '0;
    end else if (grant_i) begin
      op_write_q <= bus.i_write;
      addr_q     <= bus.i_addr;
      wdata_q    <= bus.i_wdata;
      mbe_q      <= bus.i_mbe;
    end else if (grant_d) begin
      op_write_q <= bus.d_write;
      addr_q     <= bus.d_addr;
      wdata_q    <= bus.d_wdata;
      mbe_q      <= bus.d_mbe;
    end
  end

  assign bus.l2_read  = serving & ~op_write_q;
  assign bus.l2_write = serving & op_write_q;
  assign bus.l2_addr  = addr_q;
  assign bus.l2_wdata = wdata_q;
  assign bus.l2_mbe   = mbe_q;
  assign bus.i_resp   = i_resp;
  assign bus.d_resp   = d_resp;
  assign bus.i_rdata  = bus.l2_rdata;
  assign bus.d_rdata  = bus.l2_rdata;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_l2_port_scheduler.sv
module tb_l2_port_scheduler;
  localparam int LINE_W = 256;
  localparam int MBE_W  = LINE_W / 8;
  localparam int LIMIT  = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  l2_port_scheduler_if #(.LINE_W(LINE_W)) bus ();

  l2_port_scheduler #(.STARVE_LIMIT(LIMIT), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_mbe = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mbe = '0;
    bus.l2_resp = 0; bus.l2_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    bus.i_read = 1; bus.d_write = 1; bus.l2_resp = 1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000",
        {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy});
    end
    checks++;
    if (bus.l2_addr !== 32'h0 || bus.l2_mbe !== '0 || bus.l2_wdata !== '0) begin
      errors++; $display("FAIL reset_latch addr=%h mbe=%h exp=0", bus.l2_addr, bus.l2_mbe);
    end
    tick();
    clear_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_lone_iread();
    logic [LINE_W-1:0] rd;
    rd = rand_line();
    bus.i_read = 1; bus.i_addr = 32'h0000_1040; bus.i_wdata = rand_line();
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL iread_grant_cycle got=%b exp=00", {bus.l2_read, bus.busy});
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.l2_read, bus.l2_write, bus.l2_addr, bus.i_resp} !== {2'b10, 32'h0000_1040, 1'b0}) begin
        errors++; $display("FAIL iread_strobe c=%0d rd=%b wr=%b addr=%h exp rd=1 addr=1040",
          c, bus.l2_read, bus.l2_write, bus.l2_addr);
      end
    end
    tick();
    bus.l2_resp = 1; bus.l2_rdata = rd;
    @(negedge clk);
    checks++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10 || bus.i_rdata !== rd) begin
      errors++; $display("FAIL iread_resp i=%b d=%b rdata_ok=%b exp i=1 d=0",
        bus.i_resp, bus.d_resp, bus.i_rdata === rd);
    end
    tick();
    bus.l2_resp = 0; bus.i_read = 0;
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy} !== 5'b00001) begin
      errors++; $display("FAIL iread_release got=%b exp=00001",
        {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL iread_idle busy=%b exp=0", bus.busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    logic [LINE_W-1:0] w;
    logic [MBE_W-1:0]  m;
    w = rand_line(); m = MBE_W'($urandom);
    bus.i_read = 1; bus.i_addr = 32'h0000_2000;
    bus.d_write = 1; bus.d_addr = 32'h0000_3080; bus.d_wdata = w; bus.d_mbe = m;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.l2_write, bus.l2_read, bus.l2_addr, bus.l2_mbe} !== {2'b10, 32'h0000_3080, m} ||
        bus.l2_wdata !== w) begin
      errors++; $display("FAIL prio_d_first wr=%b rd=%b addr=%h exp wr=1 addr=3080",
        bus.l2_write, bus.l2_read, bus.l2_addr);
    end
    tick();
    bus.l2_resp = 1;
    @(negedge clk);
    checks++;
    if ({bus.d_resp, bus.i_resp} !== 2'b10) begin
      errors++; $display("FAIL prio_d_resp d=%b i=%b exp d=1 i=0", bus.d_resp, bus.i_resp);
    end
    tick();
    bus.l2_resp = 0; bus.d_write = 0;
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      errors++; $display("FAIL prio_release got=%b exp=0000",
        {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp});
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_write, bus.l2_addr, bus.d_resp} !== {2'b10, 32'h0000_2000, 1'b0}) begin
      errors++; $display("FAIL prio_i_second rd=%b wr=%b addr=%h exp rd=1 addr=2000",
        bus.l2_read, bus.l2_write, bus.l2_addr);
    end
    tick();
    bus.l2_resp = 1;
    @(negedge clk);
    checks++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
      errors++; $display("FAIL prio_i_resp i=%b d=%b exp i=1 d=0", bus.i_resp, bus.d_resp);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({bus.i_resp, bus.d_resp, bus.busy} !== 3'b001) begin
      errors++; $display("FAIL prio_final got=%b exp=001", {bus.i_resp, bus.d_resp, bus.busy});
    end
    tick();
  endtask

  task automatic test_starvation();
    int dcnt, irsp;
    int d_before [2];
    bit drop_i;
    dcnt = 0; irsp = 0; drop_i = 0;
    d_before[0] = -1; d_before[1] = -1;
    bus.i_read = 1; bus.d_read = 1; bus.i_addr = 32'h100; bus.d_addr = 32'h200;
    for (int c = 0; c < 150 && irsp < 2; c++) begin
      bus.l2_resp = bus.l2_read | bus.l2_write;
      bus.i_read  = !drop_i;
      @(negedge clk);
      drop_i = bus.i_resp;
      if (bus.d_resp) dcnt++;
      if (bus.i_resp) begin
        d_before[irsp] = dcnt;
        irsp++;
        dcnt = 0;
      end
      tick();
    end
    clear_inputs();
    tick(); tick();
    checks++;
    if (irsp !== 2) begin
      errors++; $display("FAIL starve_timeout icache_grants=%0d exp=2", irsp);
    end
    checks++;
    if (d_before[0] !== LIMIT) begin
      errors++; $display("FAIL starve_first d_grants=%0d exp=%0d", d_before[0], LIMIT);
    end
    checks++;
    if (d_before[1] !== LIMIT) begin
      errors++; $display("FAIL starve_cleared d_grants=%0d exp=%0d", d_before[1], LIMIT);
    end
  endtask

  task automatic test_hold_latched();
    logic [LINE_W-1:0] w;
    logic [MBE_W-1:0]  m;
    w = rand_line(); m = MBE_W'($urandom);
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'hABCD_0040; bus.d_wdata = w; bus.d_mbe = m;
    tick();
    bus.d_addr = 32'h1111_2220; bus.d_wdata = rand_line(); bus.d_mbe = ~m;
    bus.d_read = 0; bus.d_write = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.l2_write, bus.l2_read, bus.l2_addr, bus.l2_mbe} !== {2'b10, 32'hABCD_0040, m} ||
          bus.l2_wdata !== w) begin
        errors++; $display("FAIL hold_latched c=%0d wr=%b rd=%b addr=%h wdata=%h exp addr=abcd0040 wdata=%h",
          c, bus.l2_write, bus.l2_read, bus.l2_addr, bus.l2_wdata, w);
      end
      tick();
    end
    bus.l2_resp = 1;
    @(negedge clk);
    checks++;
    if ({bus.d_resp, bus.i_resp} !== 2'b10) begin
      errors++; $display("FAIL hold_resp d=%b i=%b exp d=1 i=0", bus.d_resp, bus.i_resp);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_rst_mid();
    bus.i_read = 1; bus.i_addr = 32'h0000_5500; bus.i_mbe = MBE_W'($urandom); bus.i_wdata = rand_line();
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.l2_read !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre l2_read=%b exp=1", bus.l2_read);
    end
    tick();
    rst = 0; bus.i_read = 0; bus.l2_resp = 1; bus.l2_rdata = '0;
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy} !== 5'b0 ||
        bus.l2_addr !== 32'h0 || bus.l2_mbe !== '0 || bus.l2_wdata !== '0 || bus.i_rdata !== '0) begin
      errors++; $display("FAIL rstmid_post ctrl=%b addr=%h exp all 0",
        {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, bus.busy}, bus.l2_addr);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious_resp();
    bus.l2_resp = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.i_resp, bus.d_resp, bus.busy, bus.l2_read} !== 4'b0) begin
        errors++; $display("FAIL spurious c=%0d got=%b exp=0000", c,
          {bus.i_resp, bus.d_resp, bus.busy, bus.l2_read});
      end
      tick();
    end
    bus.l2_resp = 0; bus.d_read = 1; bus.d_addr = 32'h0000_7700;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.l2_read, bus.l2_addr} !== {1'b1, 32'h0000_7700}) begin
      errors++; $display("FAIL spurious_after rd=%b addr=%h exp rd=1 addr=7700", bus.l2_read, bus.l2_addr);
    end
    tick();
    bus.l2_resp = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    bit m_active, m_gap, m_who_i, m_write, ip, dp;
    int m_starve;
    logic [31:0]       m_addr;
    logic [LINE_W-1:0] m_wdata, rd;
    logic [MBE_W-1:0]  m_mbe;
    bit i_act, d_act, i_done, d_done, exp_ir, exp_dr;
    m_active = 0; m_gap = 0; m_who_i = 0; m_write = 0; m_starve = 0;
    m_addr = '0; m_wdata = '0; m_mbe = '0;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (i_done) begin
        bus.i_read = 0; bus.i_write = 0; i_act = 0;
      end else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1;
        bus.i_read  = 1'($urandom_range(0, 1));
        bus.i_write = !bus.i_read || ($urandom_range(0, 3) == 0);
        bus.i_addr = $urandom; bus.i_wdata = rand_line(); bus.i_mbe = MBE_W'($urandom);
      end else if (i_act && $urandom_range(0, 7) == 0) begin
        bus.i_addr = $urandom; bus.i_wdata = rand_line(); bus.i_mbe = MBE_W'($urandom);
      end
      if (d_done) begin
        bus.d_read = 0; bus.d_write = 0; d_act = 0;
      end else if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1;
        bus.d_read  = 1'($urandom_range(0, 1));
        bus.d_write = !bus.d_read || ($urandom_range(0, 3) == 0);
        bus.d_addr = $urandom; bus.d_wdata = rand_line(); bus.d_mbe = MBE_W'($urandom);
      end else if (d_act && $urandom_range(0, 7) == 0) begin
        bus.d_addr = $urandom; bus.d_wdata = rand_line(); bus.d_mbe = MBE_W'($urandom);
      end
      rd = rand_line();
      bus.l2_rdata = rd;
      bus.l2_resp  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_ir = m_active && m_who_i && bus.l2_resp;
      exp_dr = m_active && !m_who_i && bus.l2_resp;
      checks++;
      if ({bus.l2_write, bus.l2_read} !== {m_active && m_write, m_active && !m_write}) begin
        errors++; $display("FAIL rand_strobe cyc=%0d got=%b exp=%b", c,
          {bus.l2_write, bus.l2_read}, {m_active && m_write, m_active && !m_write});
      end
      checks++;
      if ({bus.l2_addr, bus.l2_mbe} !== {m_addr, m_mbe}) begin
        errors++; $display("FAIL rand_addr cyc=%0d addr=%h mbe=%h exp addr=%h mbe=%h", c,
          bus.l2_addr, bus.l2_mbe, m_addr, m_mbe);
      end
      checks++;
      if (bus.l2_wdata !== m_wdata) begin
        errors++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, bus.l2_wdata, m_wdata);
      end
      checks++;
      if ({bus.i_resp, bus.d_resp, bus.busy} !== {exp_ir, exp_dr, m_active || m_gap}) begin
        errors++; $display("FAIL rand_resp cyc=%0d i/d/busy=%b exp=%b", c,
          {bus.i_resp, bus.d_resp, bus.busy}, {exp_ir, exp_dr, m_active || m_gap});
      end
      checks++;
      if (bus.i_rdata !== rd || bus.d_rdata !== rd) begin
        errors++; $display("FAIL rand_rdata cyc=%0d i=%h d=%h exp=%h", c, bus.i_rdata, bus.d_rdata, rd);
      end
      i_done = bus.i_resp;
      d_done = bus.d_resp;
      ip = bus.i_read || bus.i_write;
      dp = bus.d_read || bus.d_write;
      if (rst) begin
        m_active = 0; m_gap = 0; m_starve = 0; m_write = 0;
        m_addr = '0; m_wdata = '0; m_mbe = '0;
      end else if (m_active) begin
        if (bus.l2_resp) begin m_active = 0; m_gap = 1; end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (ip && (!dp || m_starve == LIMIT)) begin
        m_active = 1; m_who_i = 1; m_write = bus.i_write; m_starve = 0;
        m_addr = bus.i_addr; m_wdata = bus.i_wdata; m_mbe = bus.i_mbe;
      end else if (dp) begin
        m_active = 1; m_who_i = 0; m_write = bus.d_write;
        m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_mbe = bus.d_mbe;
        if (ip && m_starve < LIMIT) m_starve++;
      end
      tick();
    end
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_lone_iread();
    test_priority();
    test_starvation();
    test_hold_latched();
    test_rst_mid();
    test_spurious_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
